// File: rtl/vga_line_fetcher.sv
// VGA line fetcher: prefetches the next display line from word-addressed
// memory into one of two ping-pong line buffers and serves pixels from the
// buffer of the line currently being scanned, flagging underruns and
// triggers that arrive while a fetch is still running.
module vga_line_fetcher #(
  parameter int RES_X     = 640,
  parameter int RES_Y     = 480,
  parameter int ADDR_W    = 20,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        COL,
  input  logic [9:0]        LINE,
  output logic [31:0]       pixel,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              err_clr,
  output logic              underrun,
  output logic              late_trig,
  output logic              busy
);

  localparam int IDX_W = (RES_X > 1) ? $clog2(RES_X) : 1;
  localparam int CNT_W = $clog2(RES_X + 1);
  localparam logic [10:0] RES_X_C = 11'(RES_X);
  localparam logic [10:0] RES_Y_C = 11'(RES_Y);

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [9:0]         target_q;
  logic [CNT_W-1:0]   word_q;
  logic [CNT_W-1:0]   fill_q [2];
  logic [31:0]        line_mem [2][RES_X];
  logic [31:0]        rd_q;
  logic               valid_q;
  logic               underrun_q;
  logic               late_q;

  // Widened copies so comparisons against the resolution stay in one width.
  logic [10:0]        col_w, line_w;
  logic               trig_hit, trig_next, trig_wrap, trigger;
  logic [9:0]         trig_line;
  logic               start, wr_en, last_word;
  logic               active, pix_ok, underrun_set, late_set;
  logic [IDX_W-1:0]   rd_idx;

  // Trigger decode, pixel qualification and error events.
  always_comb begin
    col_w        = {1'b0, COL};
    line_w       = {1'b0, LINE};
    trig_hit     = (col_w == RES_X_C);
    // LINE+1 < RES_Y is LINE < RES_Y-1 without the subtract underflowing.
    trig_next    = trig_hit && ((line_w + 11'd1) < RES_Y_C);
    trig_wrap    = trig_hit && (line_w == RES_Y_C);
    trigger      = trig_next || trig_wrap;
    trig_line    = trig_wrap ? 10'd0 : (LINE + 10'd1);
    start        = trigger && (state_q == IDLE);
    late_set     = trigger && (state_q == FETCH);
    wr_en        = (state_q == FETCH) && mem_ack;
    last_word    = (word_q == CNT_W'(RES_X - 1));
    active       = (col_w < RES_X_C) && (line_w < RES_Y_C);
    pix_ok       = active && (col_w < 11'(fill_q[LINE[0]]));
    underrun_set = active && !pix_ok;
    rd_idx       = active ? COL[IDX_W-1:0] : '0;
  end

  // FSM state register; reset aborts any fetch in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: a trigger starts a fetch, the last ack ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trigger) state_d = FETCH;
      FETCH:   if (mem_ack && last_word) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: request and busy are both "fetch in progress".
  always_comb begin
    mem_req  = (state_q == FETCH);
    busy     = (state_q == FETCH);
    mem_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(target_q) * ADDR_W'(RES_X)
             + ADDR_W'(word_q);
  end

  // Fetch bookkeeping, fill counts, pixel-valid and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q   <= '0;
      word_q     <= '0;
      fill_q[0]  <= '0;
      fill_q[1]  <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
      late_q     <= 1'b0;
    end else begin
      if (start) begin
        target_q <= trig_line;
        word_q   <= '0;
      end else if (wr_en) begin
        word_q <= word_q + CNT_W'(1);
      end
      for (int b = 0; b < 2; b++) begin
        if (start && (trig_line[0] == b[0]))
          fill_q[b] <= '0;
        else if (wr_en && (target_q[0] == b[0]))
          fill_q[b] <= fill_q[b] + CNT_W'(1);
      end
      valid_q <= pix_ok;
      // A new event in the same cycle as a clear keeps the flag set.
      if (underrun_set)  underrun_q <= 1'b1;
      else if (err_clr)  underrun_q <= 1'b0;
      if (late_set)      late_q <= 1'b1;
      else if (err_clr)  late_q <= 1'b0;
    end
  end

  // Line buffer write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) line_mem[target_q[0]][word_q[IDX_W-1:0]] <= mem_rdata;
  end

  // Line buffer registered read port for the scanned line.
  always_ff @(posedge clk) begin
    rd_q <= line_mem[LINE[0]][rd_idx];
  end

  assign pixel     = valid_q ? rd_q : 32'd0;
  assign underrun  = underrun_q;
  assign late_trig = late_q;

endmodule

// File: tb/tb_vga_line_fetcher.sv
// Directed bench for vga_line_fetcher: small 8x4 frame, memory echoes the
// word address as read data, every result compared with hand-derived values.
module tb_vga_line_fetcher;

  localparam int RX = 8;
  localparam int RY = 4;
  localparam int AW = 20;
  localparam int BA = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    col, line;
  logic [31:0]   pixel;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic          err_clr;
  logic          underrun, late_trig, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_cnt  = 0;
  int ack_base;

  vga_line_fetcher #(.RES_X(RX), .RES_Y(RY), .ADDR_W(AW), .BASE_ADDR(BA)) dut (
    .clk(clk), .rst(rst), .COL(col), .LINE(line), .pixel(pixel),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .err_clr(err_clr), .underrun(underrun),
    .late_trig(late_trig), .busy(busy)
  );

  always #5 clk = ~clk;

  assign mem_rdata = {12'd0, mem_addr};

  always @(posedge clk) if (mem_req && mem_ack) ack_cnt <= ack_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; col = 10'd9; line = 10'd0; mem_ack = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst pixel", pixel, 32'd0);
    check("rst mem_req", 32'(mem_req), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst underrun", 32'(underrun), 32'd0);
    check("rst late_trig", 32'(late_trig), 32'd0);
    tick();
    rst = 1'b0;

    // Fetch of line 1 into buffer 1, acked every cycle.
    mem_ack = 1'b1; ack_base = ack_cnt;
    col = 10'd8; line = 10'd0;
    tick();
    col = 10'd9;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("l1 addr %0d", i), 32'(mem_addr), 32'(24 + i));
      check($sformatf("l1 busy %0d", i), 32'(busy), 32'd1);
      tick();
    end
    @(negedge clk);
    check("l1 ack count", 32'(ack_cnt - ack_base), 32'd8);
    check("l1 busy fell", 32'(busy), 32'd0);
    check("l1 req low", 32'(mem_req), 32'd0);
    mem_ack = 1'b0;

    // Display line 1.
    line = 10'd1;
    for (int i = 0; i < 8; i++) begin
      col = 10'(i);
      tick();
      @(negedge clk);
      check($sformatf("l1 pixel %0d", i), pixel, 32'(24 + i));
    end
    check("l1 no underrun", 32'(underrun), 32'd0);
    col = 10'd9;

    // Wrap trigger on LINE == RES_Y fetches line 0.
    mem_ack = 1'b1;
    col = 10'd8; line = 10'd4;
    tick();
    col = 10'd9;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("l0 addr %0d", i), 32'(mem_addr), 32'(16 + i));
      tick();
    end
    @(negedge clk);
    check("l0 busy fell", 32'(busy), 32'd0);
    line = 10'd0; col = 10'd5;
    tick();
    @(negedge clk);
    check("l0 pixel 5", pixel, 32'd21);
    // LINE == RES_Y-1 and LINE > RES_Y give no trigger; stray acks ignored.
    line = 10'd3; col = 10'd8;
    tick();
    @(negedge clk);
    check("no trig line3", 32'(mem_req), 32'd0);
    line = 10'd5; col = 10'd8;
    tick();
    @(negedge clk);
    check("no trig line5", 32'(mem_req), 32'd0);
    line = 10'd0; col = 10'd7;
    tick();
    @(negedge clk);
    check("l0 pixel 7 intact", pixel, 32'd23);
    col = 10'd9;
    mem_ack = 1'b0;

    // Late trigger while a fetch is stalled.
    col = 10'd8; line = 10'd1;
    tick();
    col = 10'd9;
    @(negedge clk);
    check("l2 addr 0", 32'(mem_addr), 32'd32);
    check("late clear before", 32'(late_trig), 32'd0);
    col = 10'd8; line = 10'd2;
    tick();
    col = 10'd9;
    @(negedge clk);
    check("late set", 32'(late_trig), 32'd1);
    check("late addr held", 32'(mem_addr), 32'd32);
    check("late busy", 32'(busy), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    check("late cleared", 32'(late_trig), 32'd0);
    mem_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("l2 addr %0d", i), 32'(mem_addr), 32'(32 + i));
      tick();
      @(negedge clk);
    end
    check("l2 busy fell", 32'(busy), 32'd0);
    mem_ack = 1'b0;

    // Partial fetch of line 3 (3 of 8 words) then display it.
    col = 10'd8; line = 10'd2;
    tick();
    col = 10'd9;
    @(negedge clk);
    check("l3 addr 0", 32'(mem_addr), 32'd40);
    check("underrun before", 32'(underrun), 32'd0);
    mem_ack = 1'b1;
    tick(); tick(); tick();
    mem_ack = 1'b0;
    line = 10'd3;
    for (int i = 0; i < 8; i++) begin
      col = 10'(i);
      tick();
      @(negedge clk);
      check($sformatf("l3 pixel %0d", i), pixel, (i < 3) ? 32'(40 + i) : 32'd0);
    end
    check("l3 underrun", 32'(underrun), 32'd1);
    check("l3 still busy", 32'(busy), 32'd1);
    col = 10'd3; err_clr = 1'b1;
    tick();
    @(negedge clk);
    check("set beats clear", 32'(underrun), 32'd1);
    col = 10'd9;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    check("underrun cleared", 32'(underrun), 32'd0);

    // Asynchronous reset in the middle of the stalled fetch.
    col = 10'd0; line = 10'd3;
    tick();
    @(negedge clk);
    check("pre-rst pixel", pixel, 32'd40);
    rst = 1'b1;
    #1;
    check("async rst req", 32'(mem_req), 32'd0);
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst pixel", pixel, 32'd0);
    tick(); tick();
    rst = 1'b0; col = 10'd9; mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("post-rst req %0d", i), 32'(mem_req), 32'd0);
      tick();
    end
    mem_ack = 1'b0;
    col = 10'd0; line = 10'd3;
    tick();
    @(negedge clk);
    check("post-rst pixel", pixel, 32'd0);
    check("post-rst underrun", 32'(underrun), 32'd1);
    col = 10'd8; line = 10'd2;
    tick();
    col = 10'd9;
    @(negedge clk);
    check("refetch req", 32'(mem_req), 32'd1);
    check("refetch addr", 32'(mem_addr), 32'd40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_line_fetcher.md
VGA_LINE_FETCHER -- requirements
Module: vga_line_fetcher

Interface
REQ-001 SHALL have parameter RES_X, default 640, active pixels per line.
REQ-002 SHALL have parameter RES_Y, default 480, active lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 20, memory word-address width.
REQ-004 SHALL have parameter BASE_ADDR, default 0, word address of pixel (0,0).
REQ-005 Ports, one per line:
- clk  in  1  pixel clock, 25.175 MHz nominal.
- rst  in  1  asynchronous, active-high reset.
- COL  in  10  current column from the sync generator.
- LINE  in  10  current line from the sync generator.
- pixel  out  32  registered pixel for the generator: [23:16] R, [15:8] G, [7:0] B, [31:24] zero-passed.
- mem_req  out  1  read request.
- mem_addr  out  ADDR_W  word address; valid while mem_req is high.
- mem_ack  in  1  read accepted; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  read data.
- err_clr  in  1  clears the sticky error flags.
- underrun  out  1  sticky: an active pixel was shown before it was fetched.
- late_trig  out  1  sticky: a fetch trigger arrived while a fetch was busy.
- busy  out  1  fetch in progress.

Function
REQ-006 SHALL hold two line buffers, each RES_X x 32; buffer index = line number bit 0.
REQ-007 Fetch trigger, in the cycle where COL == RES_X:
- LINE < RES_Y-1: fetch line LINE+1.
- LINE == RES_Y: fetch line 0.
- Otherwise: no trigger.
REQ-008 FSM states are IDLE and FETCH. A trigger in IDLE SHALL go to FETCH next cycle with word counter = 0 and target line latched.
REQ-009 In FETCH, mem_req SHALL be high and mem_addr SHALL be (BASE_ADDR + target*RES_X + word) mod 2^ADDR_W; both stable until mem_ack.
REQ-010 On mem_ack, mem_rdata SHALL be written to buffer[target&1][word] and word SHALL increment; the next request may follow in the next cycle (back-to-back acks allowed).
REQ-011 The ack of word RES_X-1 SHALL return to IDLE the next cycle, with mem_req low, and SHALL mark that buffer complete.
REQ-012 busy SHALL equal (state == FETCH).
REQ-013 mem_ack while mem_req is low SHALL be ignored.
REQ-014 A trigger while in FETCH SHALL be ignored and SHALL set late_trig; the current fetch continues unchanged.
REQ-015 Each buffer SHALL keep a fill count. It resets to 0 when a fetch into that buffer starts and increments on each write.
REQ-016 Pixel latency is 1 cycle. If COL < RES_X and LINE < RES_Y at cycle t, pixel at t+1 SHALL equal buffer[LINE&1][COL]. Otherwise pixel SHALL be 0.
REQ-017 If COL < RES_X, LINE < RES_Y and COL >= fill count of buffer[LINE&1], pixel at t+1 SHALL be 0 and underrun SHALL set.
REQ-018 err_clr high SHALL clear underrun and late_trig next cycle. A set event in the same cycle wins.
REQ-019 COL and LINE are not range-checked beyond REQ-007 and REQ-016; values outside the active area only produce pixel = 0.

Reset
REQ-020 While rst is high (asynchronous), state = IDLE and pixel = 0. mem_req, busy, underrun and late_trig SHALL be 0, and fill counts and word counter = 0.
REQ-021 rst mid-fetch SHALL abort immediately and drop mem_req. Buffer contents SHALL NOT be reset.
REQ-022 After rst deasserts, the first displayed lines before their fetch completes SHALL raise underrun per REQ-017.

Verification (bench: RES_X=8, RES_Y=4, BASE_ADDR=16, mem returns rdata = addr)
REQ-023 Set LINE=0 and COL=8 for one cycle, then ack every cycle.
- Expect mem_addr 24..31 in order and 8 acks.
- busy SHALL fall the cycle after the 8th ack.
REQ-024 After REQ-023, drive LINE=1 with COL sweeping 0..7. Expect pixel = 24..31, each one cycle after its COL.
REQ-025 Set LINE=4 and COL=8.
- Expect a fetch of addresses 16..23 into buffer 0.
- On LINE=3 and LINE=5 triggers, expect no request.
REQ-026 Start a fetch and withhold mem_ack. Pulse a second trigger.
- Expect late_trig=1 and mem_addr unchanged.
- After err_clr, expect late_trig=0.
REQ-027 Start a fetch and ack only 3 words. Then display the target line with COL 0..7.
- Expect pixels for COL 0..2 to be valid.
- Expect pixel = 0 for COL 3..7, and underrun=1.
REQ-028 Assert rst mid-fetch. Expect mem_req=0, busy=0 and pixel=0 asynchronously, and no further requests until the next trigger.
